// File: rtl/kgp_alu_pkg.sv
// Shared KGP-RISC ALU definitions.
// The ALU, the main control unit and the multiply sequencer all use these
// opcodes. The sequencer state enum is also defined here.
package kgp_alu_pkg;

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'b000,
    ALU_OP_SUB = 3'b001,
    ALU_OP_AND = 3'b010,
    ALU_OP_OR  = 3'b011,
    ALU_OP_XOR = 3'b100,
    ALU_OP_SLL = 3'b101,
    ALU_OP_SRL = 3'b110,
    ALU_OP_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier for KGP-RISC.
// The block borrows the shared ALU for one add per multiplier bit and
// produces a 2*WIDTH-bit product in prod_hi:prod_lo.
//
// state  | meaning
// S_IDLE | waiting for start; product outputs hold the last result
// S_RUN  | owns the ALU, one multiplier bit consumed per cycle
// S_DONE | one-cycle done pulse, product valid, ALU released
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   start, mcand, mplier          request and operands (sampled in S_IDLE)
//   busy, done                    status; done is a one-cycle pulse
//   prod_hi, prod_lo              product halves
//   alu_own, alu_a, alu_b,
//   alu_op, alu_shamt             request to the shared ALU
//   alu_result, alu_carry         sum and carry returned by the ALU
module alu_mul_seq
  import kgp_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    count_q, count_d;

  // After count steps, only the low WIDTH-count bits of lo still hold
  // unconsumed multiplier bits; the upper bits are already product.
  logic [WIDTH-1:0]   rem_mask;
  logic               rem_zero;
  logic [CW-1:0]      remaining;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    rem_mask  = {WIDTH{1'b1}} >> count_q;
    rem_zero  = ((lo_q & rem_mask) == '0);
    remaining = CW'(WIDTH) - count_q;
    shifted   = {hi_q, lo_q} >> remaining;
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mcand;
          lo_d    = mplier;
          hi_d    = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (EARLY_EXIT && rem_zero) begin
          // Every remaining add is +0, so only the shifts are left to do.
          {hi_d, lo_d} = shifted;
          state_d      = S_DONE;
        end else begin
          // The carry becomes the new MSB; dropping it loses high product bits.
          {hi_d, lo_d} = {alu_carry, alu_result, lo_q[WIDTH-1:1]};
          count_d      = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign alu_own   = (state_q == S_RUN);
  assign prod_hi   = hi_q;
  assign prod_lo   = lo_q;
  assign alu_a     = alu_own ? hi_q : '0;
  assign alu_b     = (alu_own && lo_q[0]) ? mcand_q : '0;
  assign alu_op    = ALU_OP_ADD;
  assign alu_shamt = '0;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: EARLY_EXIT=0, dut1: EARLY_EXIT=1
  logic        st0, st1;
  logic [31:0] mc0, mp0, mc1, mp1;
  logic        busy0, done0, own0, c0, busy1, done1, own1, c1;
  logic [31:0] ph0, pl0, aa0, ab0, ar0, ph1, pl1, aa1, ab1, ar1;
  logic [2:0]  op0, op1;
  logic [4:0]  sh0, sh1;

  // Behavioural model of the shared ALU adder.
  assign {c0, ar0} = {1'b0, aa0} + {1'b0, ab0};
  assign {c1, ar1} = {1'b0, aa1} + {1'b0, ab1};

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .mcand(mc0), .mplier(mp0),
    .busy(busy0), .done(done0), .prod_hi(ph0), .prod_lo(pl0),
    .alu_own(own0), .alu_a(aa0), .alu_b(ab0), .alu_op(op0), .alu_shamt(sh0),
    .alu_result(ar0), .alu_carry(c0)
  );

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .mcand(mc1), .mplier(mp1),
    .busy(busy1), .done(done1), .prod_hi(ph1), .prod_lo(pl1),
    .alu_own(own1), .alu_a(aa1), .alu_b(ab1), .alu_op(op1), .alu_shamt(sh1),
    .alu_result(ar1), .alu_carry(c1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit sel = 1'b0;
  logic        s_done, s_own;
  logic [63:0] s_prod;
  logic [31:0] s_a, s_b;
  logic [2:0]  s_op;
  logic [4:0]  s_sh;
  assign s_done = sel ? done1 : done0;
  assign s_own  = sel ? own1  : own0;
  assign s_prod = sel ? {ph1, pl1} : {ph0, pl0};
  assign s_a    = sel ? aa1 : aa0;
  assign s_b    = sel ? ab1 : ab0;
  assign s_op   = sel ? op1 : op0;
  assign s_sh   = sel ? sh1 : sh0;

  // Latency for the early-exit variant: steps run until every multiplier
  // bit above the highest set bit is all that remains.
  function automatic int exp_lat_early(input logic [31:0] m);
    int p;
    p = -1;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return (p + 3 < 33) ? p + 3 : 33;
  endfunction

  // Called just after a rising edge; returns just after the edge that
  // follows the done cycle (the block is idle again).
  task automatic run_op(input bit which, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] prod,
                        output int own_cyc, output int alu_bad);
    bit got;
    sel = which;
    if (which) begin st1 = 1'b1; mc1 = a; mp1 = b; end
    else       begin st0 = 1'b1; mc0 = a; mp0 = b; end
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0;
    lat = 1; own_cyc = 0; alu_bad = 0; got = 1'b0; prod = '0;
    while (!got && lat < 100) begin
      @(negedge clk);
      if (s_own) begin
        own_cyc++;
        if (s_op !== 3'b000 || s_sh !== 5'd0) alu_bad++;
      end else if (s_a !== 32'd0 || s_b !== 32'd0) begin
        alu_bad++;
      end
      if (s_done === 1'b1) begin
        got = 1'b1;
        prod = s_prod;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; st0 = 1'b0; st1 = 1'b0;
    mc0 = '0; mp0 = '0; mc1 = '0; mp1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy0, done0, own0, busy1, done1, own1} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_status got=%b want=000000", {busy0, done0, own0, busy1, done1, own1});
    end
    n_cmp++;
    if ({ph0, pl0, ph1, pl1} !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_prod got=%h %h %h %h want=0", ph0, pl0, ph1, pl1);
    end
    n_cmp++;
    if ({aa0, ab0, aa1, ab1} !== 128'd0) begin
      n_bad++;
      $display("FAIL reset_alu_operands got=%h %h %h %h want=0", aa0, ab0, aa1, ab1);
    end
    n_cmp++;
    if (op0 !== 3'b000 || op1 !== 3'b000 || sh0 !== 5'd0 || sh1 !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_alu_op got=%0d %0d sh=%0d %0d want=0", op0, op1, sh0, sh1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat, own, bad;
    logic [63:0] p;
    run_op(1'b0, 32'd7, 32'd6, lat, p, own, bad);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL mul7x6_latency got=%0d want=33", lat); end
    n_cmp++;
    if (p !== 64'd42) begin n_bad++; $display("FAIL mul7x6_prod got=%h want=%h", p, 64'd42); end
    n_cmp++;
    if (own !== 32) begin n_bad++; $display("FAIL mul7x6_own_cycles got=%0d want=32", own); end
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL mul7x6_alu_bus got=%0d bad cycles want=0", bad); end
    for (int d = 0; d < 2; d++) begin
      run_op(d[0], 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, own, bad);
      n_cmp++;
      if (p !== 64'hFFFF_FFFE_0000_0001) begin
        n_bad++;
        $display("FAIL max_prod dut%0d got=%h want=fffffffe00000001", d, p);
      end
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL max_latency dut%0d got=%0d want=33", d, lat); end
    end
  endtask

  task automatic test_zero_mplier();
    int lat, own, bad;
    logic [63:0] p;
    logic [31:0] a;
    a = $urandom;
    run_op(1'b1, a, 32'd0, lat, p, own, bad);
    n_cmp++;
    if (lat !== 2 || p !== 64'd0) begin
      n_bad++;
      $display("FAIL zero_early got lat=%0d prod=%h want lat=2 prod=0", lat, p);
    end
    run_op(1'b0, a, 32'd0, lat, p, own, bad);
    n_cmp++;
    if (lat !== 33 || p !== 64'd0) begin
      n_bad++;
      $display("FAIL zero_full got lat=%0d prod=%h want lat=33 prod=0", lat, p);
    end
  endtask

  task automatic test_random();
    int lat, own, bad;
    logic [63:0] p, e;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      e = 64'(a) * 64'(b);
      run_op(1'b0, a, b, lat, p, own, bad);
      n_cmp++;
      if (p !== e || lat !== 33 || own !== 32 || bad !== 0) begin
        n_bad++;
        $display("FAIL rand_full %h*%h got prod=%h lat=%0d own=%0d bad=%0d want prod=%h lat=33 own=32 bad=0",
                 a, b, p, lat, own, bad, e);
      end
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      b = b >> $urandom_range(0, 32);
      e = 64'(a) * 64'(b);
      run_op(1'b1, a, b, lat, p, own, bad);
      n_cmp++;
      if (p !== e || lat !== exp_lat_early(b) || bad !== 0) begin
        n_bad++;
        $display("FAIL rand_early %h*%h got prod=%h lat=%0d bad=%0d want prod=%h lat=%0d bad=0",
                 a, b, p, lat, bad, e, exp_lat_early(b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, m;
    logic [63:0] p1, p2;
    logic [31:0] a, b, c, d;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    sel = 1'b0;
    st0 = 1'b1; mc0 = a; mp0 = b;
    @(posedge clk); #1;
    mc0 = c; mp0 = d;
    n = 1; p1 = '0;
    @(negedge clk);
    while (done0 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      @(negedge clk);
    end
    p1 = {ph0, pl0};
    n_cmp++;
    if (n !== 33 || p1 !== 64'(a) * 64'(b)) begin
      n_bad++;
      $display("FAIL b2b_first got lat=%0d prod=%h want lat=33 prod=%h", n, p1, 64'(a) * 64'(b));
    end
    m = 0;
    @(posedge clk); #1; m++;
    @(negedge clk);
    while (done0 !== 1'b1 && m < 100) begin
      @(posedge clk); #1; m++;
      @(negedge clk);
    end
    p2 = {ph0, pl0};
    st0 = 1'b0;
    n_cmp++;
    if (m !== 34 || p2 !== 64'(c) * 64'(d)) begin
      n_bad++;
      $display("FAIL b2b_second got gap=%0d prod=%h want gap=34 prod=%h", m, p2, 64'(c) * 64'(d));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, own, bad, seen;
    logic [63:0] p;
    sel = 1'b0;
    st0 = 1'b1; mc0 = $urandom; mp0 = $urandom | 32'h8000_0000;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy0, own0, done0} !== 3'b000 || {ph0, pl0} !== 64'd0) begin
      n_bad++;
      $display("FAIL midrun_reset got busy=%b own=%b done=%b prod=%h want 0 0 0 0",
               busy0, own0, done0, {ph0, pl0});
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midrun_no_done got=%0d active cycles want=0", seen); end
    @(posedge clk); #1;
    run_op(1'b0, 32'd3, 32'd5, lat, p, own, bad);
    n_cmp++;
    if (p !== 64'd15 || lat !== 33) begin
      n_bad++;
      $display("FAIL midrun_recover got prod=%h lat=%0d want prod=f lat=33", p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_mplier();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
